// File: rtl/pdm_demod.sv
// ---------------------------------------------------------------------------
// pdm_demod
// First-order PDM demodulator. Counts ones in a 1-bit pulse-density stream
// over fixed windows of 2**DECIM_LOG2 clocks and presents each window count,
// saturated to DECIM_LOG2 bits, in a holding register with a valid/ack
// handshake and sticky overrun detection.
//
// Parameters:
//   DECIM_LOG2   log2 of window length N (legal 2..8); also the sample width
//
// Ports:
//   clk          in   1           rising-edge clock
//   reset        in   1           asynchronous, active-high reset
//   enable       in   1           run demodulation; low discards the window
//   pdm_in       in   1           PDM bitstream, one bit per clk
//   sample       out  DECIM_LOG2  last completed window count, saturated
//   sample_valid out  1           sample holds an unacknowledged result
//   sample_ack   in   1           consumer accepts sample
//   overrun      out  1           sticky: a result was overwritten unacked
//
// Build option:
//   PDM_DEMOD_SYNC_EN  when defined, pdm_in passes through a 2-flop
//                      synchronizer (independent of enable) before counting.
// ---------------------------------------------------------------------------
module pdm_demod #(
    parameter int DECIM_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pdm_in,
    output logic [DECIM_LOG2-1:0] sample,
    output logic                  sample_valid,
    input  logic                  sample_ack,
    output logic                  overrun
);

    // Window position N-1 and the largest representable sample are both
    // all-ones at DECIM_LOG2 bits.
    localparam logic [DECIM_LOG2-1:0] WCNT_LAST  = {DECIM_LOG2{1'b1}};
    localparam logic [DECIM_LOG2-1:0] SAMPLE_MAX = {DECIM_LOG2{1'b1}};
    localparam logic [DECIM_LOG2-1:0] WCNT_ONE   = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

    logic [DECIM_LOG2-1:0] wcnt_r;
    logic [DECIM_LOG2:0]   ones_r;
    logic                  bit_s;
    logic [DECIM_LOG2:0]   total_s;
    logic [DECIM_LOG2-1:0] sat_s;
    logic                  last_s;

`ifdef PDM_DEMOD_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for an asynchronous PDM source; runs regardless of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pdm_in};
        end
    end

    assign bit_s = sync_r[1];
`else
    assign bit_s = pdm_in;
`endif

    // Window total including the current bit, and its saturated sample value.
    always_comb begin
        total_s = ones_r + {{DECIM_LOG2{1'b0}}, bit_s};
        last_s  = (wcnt_r == WCNT_LAST);
        // A full window of ones (N) does not fit; clamp it to N-1.
        if (total_s[DECIM_LOG2]) begin
            sat_s = SAMPLE_MAX;
        end else begin
            sat_s = total_s[DECIM_LOG2-1:0];
        end
    end

    // Window counting, result holding register and handshake/overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_r       <= {DECIM_LOG2{1'b0}};
            ones_r       <= {(DECIM_LOG2+1){1'b0}};
            sample       <= {DECIM_LOG2{1'b0}};
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (!enable) begin
            // Partial window is discarded; the held result stays readable.
            wcnt_r  <= {DECIM_LOG2{1'b0}};
            ones_r  <= {(DECIM_LOG2+1){1'b0}};
            overrun <= 1'b0;
            if (sample_ack) begin
                sample_valid <= 1'b0;
            end else begin
                sample_valid <= sample_valid;
            end
        end else if (last_s) begin
            wcnt_r       <= {DECIM_LOG2{1'b0}};
            ones_r       <= {(DECIM_LOG2+1){1'b0}};
            sample       <= sat_s;
            sample_valid <= 1'b1;
            // An ack on the completion edge consumes the old result in time.
            if (sample_valid && !sample_ack) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end else begin
            wcnt_r <= wcnt_r + WCNT_ONE;
            ones_r <= total_s;
            if (sample_ack) begin
                sample_valid <= 1'b0;
            end else begin
                sample_valid <= sample_valid;
            end
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// ---------------------------------------------------------------------------
// tb_pdm_demod
// Scoreboard bench for pdm_demod (N = 32, default build). Stimulus pushes
// the expected value of each result it provokes; a monitor pops and compares
// whenever sample_valid rises. Handshake corner cases are checked directly.
// ---------------------------------------------------------------------------
module tb_pdm_demod;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pdm_in;
    logic [4:0] sample;
    logic       sample_valid;
    logic       sample_ack;
    logic       overrun;

    int         checks;
    int         failures;
    int         exp_q[$];
    logic       mon_prev_valid;
    logic [4:0] mod_acc;

    pdm_demod #(.DECIM_LOG2(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pdm_in       (pdm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack),
        .overrun      (overrun)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One cycle with enable low clears the window; caller then sets up and enables.
    task automatic restart();
        enable = 1'b0;
        step(1);
    endtask

    // Drive a 5-bit first-order modulator with constant input v for n cycles.
    task automatic run_mod(input int v, input int n);
        logic [5:0] sum;
        for (int i = 0; i < n; i++) begin
            sum     = {1'b0, mod_acc} + v[5:0];
            pdm_in  = sum[5];
            mod_acc = sum[4:0];
            step(1);
        end
    endtask

    // Alternate 1/0 for n cycles.
    task automatic run_alt(input int n);
        for (int i = 0; i < n; i++) begin
            pdm_in = ~pdm_in;
            step(1);
        end
    endtask

    // Monitor: every rising sample_valid presents a new result to compare.
    initial begin
        mon_prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && sample_valid && !mon_prev_valid) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL scoreboard_unexpected actual=%0d required=none", sample);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (sample !== e[4:0]) begin
                        failures = failures + 1;
                        $display("FAIL scoreboard_sample actual=%0d required=%0d", sample, e);
                    end
                end
            end
            mon_prev_valid = sample_valid;
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        pdm_in     = 1'b0;
        sample_ack = 1'b0;
        mod_acc    = 5'd0;
        step(3);
        check("reset_sample", sample, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_overrun", overrun, 0);

        // All ones from reset release: 32 saturates to 31, every 32 cycles.
        reset      = 1'b0;
        enable     = 1'b1;
        pdm_in     = 1'b1;
        sample_ack = 1'b1;
        exp_q.push_back(31);
        exp_q.push_back(31);
        exp_q.push_back(31);
        step(31);
        check("ones_valid_before_32", sample_valid, 0);
        step(1);
        check("ones_valid_at_32", sample_valid, 1);
        check("ones_sample_at_32", sample, 31);
        step(1);
        check("ones_ack_clears", sample_valid, 0);
        step(63);

        // All zeros, acked: zero results, no overrun.
        restart();
        pdm_in = 1'b0;
        enable = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        step(96);
        check("zeros_overrun", overrun, 0);

        // Modulator loopback: 20 then 13, switched on a window boundary.
        restart();
        enable = 1'b1;
        exp_q.push_back(20);
        exp_q.push_back(20);
        exp_q.push_back(20);
        run_mod(20, 96);
        exp_q.push_back(13);
        exp_q.push_back(13);
        exp_q.push_back(13);
        run_mod(13, 96);
        check("loop_overrun", overrun, 0);

        // Overrun: 1010 pattern, two completions without ack.
        restart();
        sample_ack = 1'b0;
        pdm_in     = 1'b0;
        enable     = 1'b1;
        exp_q.push_back(16);
        run_alt(32);
        check("ovr_first_overrun", overrun, 0);
        run_alt(32);
        check("ovr_second_overrun", overrun, 1);
        check("ovr_second_sample", sample, 16);
        check("ovr_second_valid", sample_valid, 1);
        sample_ack = 1'b1;
        step(1);
        check("ovr_ack_clears_valid", sample_valid, 0);
        sample_ack = 1'b0;
        step(5);
        check("ovr_sticky", overrun, 1);
        enable = 1'b0;
        step(1);
        check("ovr_cleared_by_disable", overrun, 0);
        check("ovr_sample_held", sample, 16);

        // Ack coinciding with a completion edge: new value loads, no overrun.
        restart();
        sample_ack = 1'b0;
        pdm_in     = 1'b1;
        enable     = 1'b1;
        exp_q.push_back(31);
        step(32);
        check("ackc_first_sample", sample, 31);
        pdm_in = 1'b0;
        step(31);
        check("ackc_still_valid", sample_valid, 1);
        sample_ack = 1'b1;
        step(1);
        check("ackc_valid_stays", sample_valid, 1);
        check("ackc_new_sample", sample, 0);
        check("ackc_overrun", overrun, 0);
        step(1);
        check("ackc_then_cleared", sample_valid, 0);

        // Drop enable at wcnt=10 for 5 edges, then a full window of ones.
        restart();
        pdm_in = 1'b1;
        enable = 1'b1;
        step(10);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        exp_q.push_back(31);
        step(31);
        check("reen_valid_before_32", sample_valid, 0);
        step(1);
        check("reen_valid_at_32", sample_valid, 1);
        check("reen_sample", sample, 31);
        step(2);

        // Build up valid + overrun, then reset asynchronously at wcnt=7.
        restart();
        sample_ack = 1'b0;
        pdm_in     = 1'b1;
        enable     = 1'b1;
        exp_q.push_back(31);
        step(64);
        check("pre_reset_overrun", overrun, 1);
        step(7);
        reset = 1'b1;
        #1;
        check("async_reset_sample", sample, 0);
        check("async_reset_valid", sample_valid, 0);
        check("async_reset_overrun", overrun, 0);
        @(negedge clk);
        reset      = 1'b0;
        sample_ack = 1'b1;
        exp_q.push_back(31);
        step(31);
        check("post_reset_valid_before_32", sample_valid, 0);
        step(1);
        check("post_reset_valid_at_32", sample_valid, 1);
        step(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
